// File: rtl/kernel_pkg.sv
// Shared constants, state encoding and 3x3 tap-offset lookup for the kernel window path.
package kernel_pkg;

    localparam int DEF_IMG_W  = 64;
    localparam int DEF_IMG_H  = 64;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // tap_idx = 3*(dy+1) + (dx+1)
    function automatic logic signed [1:0] tap_dx(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd3, 4'd6: tap_dx = -2'sd1;
            4'd1, 4'd4, 4'd7: tap_dx = 2'sd0;
            default:          tap_dx = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] tap_dy(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: tap_dy = -2'sd1;
            4'd3, 4'd4, 4'd5: tap_dy = 2'sd0;
            default:          tap_dy = 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/kernel_addr_gen.sv
// Combinational neighbour address generator: pixel + tap offset -> ROM address and pad flag.
module kernel_addr_gen
    import kernel_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W/2-1:0] px_x,
    input  logic [ADDR_W/2-1:0] px_y,
    input  logic [3:0]          tap_idx,
    output logic [ADDR_W-1:0]   addr,
    output logic                pad
);

    localparam int XW = ADDR_W / 2;
    localparam int CW = XW + 2;

    logic signed [1:0]    dx, dy;
    logic signed [CW-1:0] nx, ny;
    logic signed [31:0]   lin;

    always_comb begin
        dx  = tap_dx(tap_idx);
        dy  = tap_dy(tap_idx);
        nx  = $signed({2'b00, px_x}) + $signed({{(CW-2){dx[1]}}, dx});
        ny  = $signed({2'b00, px_y}) + $signed({{(CW-2){dy[1]}}, dy});
        pad = (nx < 0) || (32'(nx) >= IMG_W) || (ny < 0) || (32'(ny) >= IMG_H);
        lin = 32'(ny) * IMG_W + 32'(nx);
        addr = pad ? '0 : ADDR_W'(lin);
    end

endmodule

// File: rtl/kernel_window_sequencer.sv
// Walks every output pixel in raster order, issuing its nine 3x3 neighbour taps over valid/ready.
module kernel_window_sequencer
    import kernel_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                tap_valid,
    input  logic                tap_ready,
    output logic [DATA_W-1:0]   tap_data,
    output logic [3:0]          tap_idx,
    output logic                tap_pad,
    output logic                tap_last,
    output logic [ADDR_W/2-1:0] px_x,
    output logic [ADDR_W/2-1:0] px_y,
    output logic                frame_last
);

    localparam int XW = ADDR_W / 2;

    state_t            state, state_n;
    logic [XW-1:0]     x_n, y_n;
    logic [3:0]        idx_n;
    logic [ADDR_W-1:0] addr_n;
    logic              pad_n;
    logic              hs;

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign tap_valid  = (state == RUN);
    assign hs         = tap_valid & tap_ready;
    assign tap_last   = (tap_idx == 4'd8);
    assign frame_last = tap_last && (px_x == XW'(IMG_W - 1)) && (px_y == XW'(IMG_H - 1));
    assign tap_data   = tap_pad ? '0 : rom_data;

    // Address/pad are looked up for the counters' next value so both register alongside them.
    kernel_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .px_x    (x_n),
        .px_y    (y_n),
        .tap_idx (idx_n),
        .addr    (addr_n),
        .pad     (pad_n)
    );

    always_comb begin
        state_n = state;
        x_n     = px_x;
        y_n     = px_y;
        idx_n   = tap_idx;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = RUN;
                    x_n     = '0;
                    y_n     = '0;
                    idx_n   = '0;
                end
            end
            RUN: begin
                if (abort || (hs && frame_last)) begin
                    state_n = abort ? IDLE : DONE;
                    x_n     = '0;
                    y_n     = '0;
                    idx_n   = '0;
                end else if (hs) begin
                    if (!tap_last) begin
                        idx_n = tap_idx + 4'd1;
                    end else begin
                        idx_n = '0;
                        if (px_x == XW'(IMG_W - 1)) begin
                            x_n = '0;
                            y_n = px_y + XW'(1);
                        end else begin
                            x_n = px_x + XW'(1);
                        end
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pad resets high: counters at (0,0) tap 0 point above-left of the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            px_x     <= '0;
            px_y     <= '0;
            tap_idx  <= '0;
            rom_addr <= '0;
            tap_pad  <= 1'b1;
        end else begin
            state    <= state_n;
            px_x     <= x_n;
            px_y     <= y_n;
            tap_idx  <= idx_n;
            rom_addr <= addr_n;
            tap_pad  <= pad_n;
        end
    end

endmodule
